// File: rtl/psum_xchg_pkg.sv
// Shared definitions for the inter-core partial-sum exchange.
// Holds the exchange FSM state encoding and the default widths/limits so the
// transmit side, receive side and fullchip glue all agree on the word format.
package psum_xchg_pkg;

    localparam int unsigned BW_PSUM = 20;            // per-column psum width
    localparam int unsigned SUM_BW  = BW_PSUM + 4;   // one core's row sum on the FIFO
    localparam int unsigned TIMEOUT = 1024;          // WAIT cycles before timeout_err
    localparam int unsigned CNT_BW  = 16;            // exchange counter width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        LAT  = 2'd2,
        HOLD = 2'd3
    } xchg_state_e;

endpackage

// File: rtl/psum_xchg_rx_xchg_timer.sv
// WAIT-cycle timer for the exchange receive side.
// Counts cycles spent waiting on an empty peer FIFO, saturating so the
// threshold pulse fires once per exchange.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   clr_i  : restart the count (new exchange captured)
//   inc_i  : one more cycle spent waiting on an empty FIFO
//   hit_o  : single-cycle pulse on the cycle the count sits at timeout-1
module xchg_timer
    import psum_xchg_pkg::*;
#(
    parameter int unsigned timeout = TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic hit_o
);

    localparam int unsigned TW = $clog2(timeout + 1);
    localparam logic [TW-1:0] LAST = TW'(timeout - 1);
    localparam logic [TW-1:0] SAT  = TW'(timeout);

    logic [TW-1:0] cnt_q, cnt_d;

    // Stopping at `timeout` (one past LAST) keeps the threshold pulse single-shot
    // while the stall continues.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != SAT)) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_o = inc_i && (cnt_q == LAST);

endmodule

// File: rtl/psum_xchg_rx.sv
// Receive-side endpoint of the inter-core partial-sum exchange.
// Takes the local core's row sum, pops the peer's sum from the inter-core FIFO
// (only when it is non-empty), adds the two and offers the total to the local
// normaliser over valid/ready.
//   clk          : clock, rising edge
//   reset        : asynchronous active-low reset
//   local_sum    : local row sum (unsigned), qualified by local_vld
//   local_rdy    : local_sum accepted this cycle
//   fifo_empty   : peer FIFO empty flag
//   fifo_rd      : one-cycle pop strobe; data arrives on fifo_rd_data next cycle
//   sum_out      : local + peer, one bit wider than a row sum, qualified by out_vld
//   out_rdy      : normaliser accepts sum_out
//   timeout_err  : sticky, peer sum overdue; cleared by err_clr (set wins)
//   xchg_cnt     : completed exchanges, wrapping
module psum_xchg_rx
    import psum_xchg_pkg::*;
#(
    parameter int unsigned bw_psum = BW_PSUM,
    // Guard-bit offset is shared with the transmit side through the package.
    parameter int unsigned sum_bw  = bw_psum + (SUM_BW - BW_PSUM),
    parameter int unsigned timeout = TIMEOUT,
    parameter int unsigned cnt_bw  = CNT_BW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [sum_bw-1:0] local_sum,
    input  logic              local_vld,
    output logic              local_rdy,
    input  logic              fifo_empty,
    output logic              fifo_rd,
    input  logic [sum_bw-1:0] fifo_rd_data,
    output logic [sum_bw:0]   sum_out,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic              timeout_err,
    input  logic              err_clr,
    output logic [cnt_bw-1:0] xchg_cnt
);

    xchg_state_e state_q, state_d;

    logic [sum_bw-1:0] local_q, local_d;
    logic [sum_bw:0]   sum_q, sum_d;
    logic [cnt_bw-1:0] cnt_q, cnt_d;
    logic              err_q, err_d;

    logic capture;   // local_sum taken this cycle (IDLE, or HOLD back-to-back)
    logic accept;    // sum_out handed to the normaliser this cycle
    logic tmr_inc;
    logic tmr_hit;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (local_vld)   state_d = WAIT;
            WAIT: if (!fifo_empty) state_d = LAT;
            LAT:                   state_d = HOLD;
            HOLD: if (out_rdy)     state_d = local_vld ? WAIT : IDLE;
            default:               state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        local_rdy = (state_q == IDLE) || ((state_q == HOLD) && out_rdy);
        // Pop is only possible in WAIT, and WAIT is left on the same edge,
        // so each exchange pops exactly once.
        fifo_rd   = (state_q == WAIT) && !fifo_empty;
        out_vld   = (state_q == HOLD);
        capture   = local_rdy && local_vld;
        accept    = out_vld && out_rdy;
        tmr_inc   = (state_q == WAIT) && fifo_empty;
    end

    // ---------------- Datapath ----------------
    always_comb begin
        local_d = capture ? local_sum : local_q;
        // fifo_rd_data is only meaningful the cycle after the pop, i.e. in LAT.
        sum_d   = (state_q == LAT) ? ({1'b0, local_q} + {1'b0, fifo_rd_data}) : sum_q;
        cnt_d   = accept ? (cnt_q + cnt_bw'(1)) : cnt_q;
        err_d   = tmr_hit || (err_q && !err_clr);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            local_q <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            local_q <= local_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    xchg_timer #(
        .timeout (timeout)
    ) u_timer (
        .clk   (clk),
        .rst_n (reset),
        .clr_i (capture),
        .inc_i (tmr_inc),
        .hit_o (tmr_hit)
    );

    assign sum_out     = sum_q;
    assign xchg_cnt    = cnt_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_psum_xchg_rx.sv
// Directed bench for psum_xchg_rx with a small FIFO model on the read side.
// Inputs are driven 1 ns after the rising edge and outputs checked 1 ns later.
module tb_psum_xchg_rx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] local_sum = '0;
    logic        local_vld = 1'b0;
    logic        local_rdy;
    logic        fifo_empty;
    logic        fifo_rd;
    logic [23:0] fifo_rd_data = '0;
    logic [24:0] sum_out;
    logic        out_vld;
    logic        out_rdy = 1'b0;
    logic        timeout_err;
    logic        err_clr = 1'b0;
    logic [15:0] xchg_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Peer FIFO model: data appears the cycle after a pop, garbage otherwise.
    logic [23:0] fifo_mem [0:15];
    int unsigned wr_ptr = 0;
    int unsigned rd_ptr = 0;
    logic        hold_empty = 1'b0;

    assign fifo_empty = hold_empty || (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd) begin
            fifo_rd_data <= fifo_mem[rd_ptr[3:0]];
            rd_ptr       <= rd_ptr + 1;
        end else begin
            fifo_rd_data <= 24'hA5A5A5;
        end
    end

    psum_xchg_rx #(
        .bw_psum (20),
        .sum_bw  (24),
        .timeout (8),
        .cnt_bw  (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .local_sum    (local_sum),
        .local_vld    (local_vld),
        .local_rdy    (local_rdy),
        .fifo_empty   (fifo_empty),
        .fifo_rd      (fifo_rd),
        .fifo_rd_data (fifo_rd_data),
        .sum_out      (sum_out),
        .out_vld      (out_vld),
        .out_rdy      (out_rdy),
        .timeout_err  (timeout_err),
        .err_clr      (err_clr),
        .xchg_cnt     (xchg_cnt)
    );

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [23:0] w);
        fifo_mem[wr_ptr[3:0]] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic test_reset;
        #2 reset = 1'b0;
        #1;
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL reset_out_vld: got %b expected 0", out_vld); end
        checks++; if (local_rdy !== 1'b1) begin errors++; $display("FAIL reset_local_rdy: got %b expected 1", local_rdy); end
        checks++; if (fifo_rd !== 1'b0) begin errors++; $display("FAIL reset_fifo_rd: got %b expected 0", fifo_rd); end
        checks++; if (xchg_cnt !== 16'd0) begin errors++; $display("FAIL reset_xchg_cnt: got %h expected 0", xchg_cnt); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); end
        checks++; if (sum_out !== 25'd0) begin errors++; $display("FAIL reset_sum_out: got %h expected 0", sum_out); end
        cyc;
        cyc;
        reset = 1'b1;
    endtask

    // One full exchange with out_rdy held high; checks cycle-by-cycle latency.
    task automatic run_exchange(input logic [23:0] loc, input logic [23:0] peer,
                                input logic [24:0] exp_sum, input logic [15:0] exp_cnt,
                                input int unsigned exp_pops);
        push(peer);
        out_rdy = 1'b1;
        cyc; local_sum = loc; local_vld = 1'b1; #1;           // cycle 0
        checks++; if (local_rdy !== 1'b1) begin errors++; $display("FAIL xchg_c0_local_rdy: got %b expected 1", local_rdy); end
        checks++; if (fifo_rd !== 1'b0) begin errors++; $display("FAIL xchg_c0_fifo_rd: got %b expected 0", fifo_rd); end
        cyc; local_vld = 1'b0; #1;                            // cycle 1
        checks++; if (fifo_rd !== 1'b1) begin errors++; $display("FAIL xchg_c1_fifo_rd: got %b expected 1", fifo_rd); end
        checks++; if (local_rdy !== 1'b0) begin errors++; $display("FAIL xchg_c1_local_rdy: got %b expected 0", local_rdy); end
        cyc; #1;                                              // cycle 2
        checks++; if (fifo_rd !== 1'b0) begin errors++; $display("FAIL xchg_c2_fifo_rd: got %b expected 0", fifo_rd); end
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL xchg_c2_out_vld: got %b expected 0", out_vld); end
        cyc; #1;                                              // cycle 3
        checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL xchg_c3_out_vld: got %b expected 1", out_vld); end
        checks++; if (sum_out !== exp_sum) begin errors++; $display("FAIL xchg_c3_sum_out: got %h expected %h", sum_out, exp_sum); end
        checks++; if (local_rdy !== 1'b1) begin errors++; $display("FAIL xchg_c3_local_rdy: got %b expected 1", local_rdy); end
        cyc; #1;                                              // cycle 4
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL xchg_c4_out_vld: got %b expected 0", out_vld); end
        checks++; if (xchg_cnt !== exp_cnt) begin errors++; $display("FAIL xchg_c4_cnt: got %0d expected %0d", xchg_cnt, exp_cnt); end
        checks++; if (rd_ptr !== exp_pops) begin errors++; $display("FAIL xchg_c4_pops: got %0d expected %0d", rd_ptr, exp_pops); end
    endtask

    task automatic test_basic;
        run_exchange(24'h000123, 24'h000456, 25'h0000579, 16'd1, 1);
    endtask

    task automatic test_max;
        run_exchange(24'hFFFFFF, 24'hFFFFFF, 25'h1FFFFFE, 16'd2, 2);
    endtask

    task automatic test_timeout;
        logic exp_err;
        push(24'h000100);
        hold_empty = 1'b1;
        out_rdy = 1'b1;
        cyc; local_sum = 24'h000011; local_vld = 1'b1; #1;   // cycle 0
        for (int k = 1; k <= 20; k++) begin                  // WAIT cycles 1..20
            cyc;
            local_vld = 1'b0;
            err_clr = (k == 8);   // collides with the set pulse in cycle 8
            #1;
            exp_err = (k >= 9);
            checks++; if (fifo_rd !== 1'b0) begin errors++; $display("FAIL stall_fifo_rd c%0d: got %b expected 0", k, fifo_rd); end
            checks++; if (timeout_err !== exp_err) begin errors++; $display("FAIL stall_timeout_err c%0d: got %b expected %b", k, timeout_err, exp_err); end
        end
        cyc; err_clr = 1'b0; hold_empty = 1'b0; #1;          // cycle 21
        checks++; if (fifo_rd !== 1'b1) begin errors++; $display("FAIL stall_release_fifo_rd: got %b expected 1", fifo_rd); end
        cyc; #1;                                              // cycle 22
        checks++; if (fifo_rd !== 1'b0) begin errors++; $display("FAIL stall_single_pop: got %b expected 0", fifo_rd); end
        cyc; #1;                                              // cycle 23
        checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL stall_out_vld: got %b expected 1", out_vld); end
        checks++; if (sum_out !== 25'h0000111) begin errors++; $display("FAIL stall_sum_out: got %h expected 0000111", sum_out); end
        cyc; err_clr = 1'b1; #1;                              // cycle 24
        checks++; if (xchg_cnt !== 16'd3) begin errors++; $display("FAIL stall_cnt: got %0d expected 3", xchg_cnt); end
        checks++; if (rd_ptr !== 32'd3) begin errors++; $display("FAIL stall_pops: got %0d expected 3", rd_ptr); end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL stall_err_sticky: got %b expected 1", timeout_err); end
        cyc; err_clr = 1'b0; #1;                              // cycle 25
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL err_clr: got %b expected 0", timeout_err); end
    endtask

    task automatic test_back_to_back;
        push(24'd10);
        push(24'd20);
        out_rdy = 1'b0;
        cyc; local_sum = 24'd1; local_vld = 1'b1; #1;        // cycle 0
        cyc; local_vld = 1'b0; #1;                            // cycle 1
        checks++; if (fifo_rd !== 1'b1) begin errors++; $display("FAIL b2b_c1_fifo_rd: got %b expected 1", fifo_rd); end
        cyc;                                                  // cycle 2
        for (int k = 3; k <= 7; k++) begin                   // backpressure cycles
            cyc;
            local_sum = 24'd2;
            local_vld = 1'b1;
            #1;
            checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL bp_out_vld c%0d: got %b expected 1", k, out_vld); end
            checks++; if (sum_out !== 25'd11) begin errors++; $display("FAIL bp_sum_out c%0d: got %0d expected 11", k, sum_out); end
            checks++; if (local_rdy !== 1'b0) begin errors++; $display("FAIL bp_local_rdy c%0d: got %b expected 0", k, local_rdy); end
        end
        cyc; out_rdy = 1'b1; #1;                              // cycle 8
        checks++; if (local_rdy !== 1'b1) begin errors++; $display("FAIL b2b_c8_local_rdy: got %b expected 1", local_rdy); end
        checks++; if (sum_out !== 25'd11) begin errors++; $display("FAIL b2b_c8_sum_out: got %0d expected 11", sum_out); end
        cyc; local_vld = 1'b0; #1;                            // cycle 9: straight to WAIT
        checks++; if (fifo_rd !== 1'b1) begin errors++; $display("FAIL b2b_c9_fifo_rd: got %b expected 1", fifo_rd); end
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL b2b_c9_out_vld: got %b expected 0", out_vld); end
        checks++; if (local_rdy !== 1'b0) begin errors++; $display("FAIL b2b_c9_local_rdy: got %b expected 0", local_rdy); end
        checks++; if (xchg_cnt !== 16'd4) begin errors++; $display("FAIL b2b_c9_cnt: got %0d expected 4", xchg_cnt); end
        cyc;                                                  // cycle 10
        cyc; #1;                                              // cycle 11
        checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL b2b_c11_out_vld: got %b expected 1", out_vld); end
        checks++; if (sum_out !== 25'd22) begin errors++; $display("FAIL b2b_c11_sum_out: got %0d expected 22", sum_out); end
        cyc; #1;                                              // cycle 12
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL b2b_c12_out_vld: got %b expected 0", out_vld); end
        checks++; if (xchg_cnt !== 16'd5) begin errors++; $display("FAIL b2b_c12_cnt: got %0d expected 5", xchg_cnt); end
        checks++; if (rd_ptr !== 32'd5) begin errors++; $display("FAIL b2b_c12_pops: got %0d expected 5", rd_ptr); end
    endtask

    task automatic test_reset_mid_hold;
        push(24'h000777);
        out_rdy = 1'b0;
        cyc; local_sum = 24'd1; local_vld = 1'b1; #1;        // cycle 0
        cyc; local_vld = 1'b0;                                // cycle 1
        cyc;                                                  // cycle 2
        cyc; #1;                                              // cycle 3: HOLD
        checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL mid_hold_out_vld: got %b expected 1", out_vld); end
        #1 reset = 1'b0;                                      // between edges
        #1;
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL async_rst_out_vld: got %b expected 0", out_vld); end
        checks++; if (fifo_rd !== 1'b0) begin errors++; $display("FAIL async_rst_fifo_rd: got %b expected 0", fifo_rd); end
        checks++; if (local_rdy !== 1'b1) begin errors++; $display("FAIL async_rst_local_rdy: got %b expected 1", local_rdy); end
        checks++; if (xchg_cnt !== 16'd0) begin errors++; $display("FAIL async_rst_cnt: got %0d expected 0", xchg_cnt); end
        checks++; if (sum_out !== 25'd0) begin errors++; $display("FAIL async_rst_sum_out: got %h expected 0", sum_out); end
        cyc;
        cyc; reset = 1'b1;
        cyc; #1;
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL post_rst_out_vld: got %b expected 0", out_vld); end
        checks++; if (local_rdy !== 1'b1) begin errors++; $display("FAIL post_rst_local_rdy: got %b expected 1", local_rdy); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_max;
        test_timeout;
        test_back_to_back;
        test_reset_mid_hold;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
